// File: rtl/register_file_sb.sv
// register_file_sb: scoreboarded register file with x0 hardwired to zero; define REGFILE_BYPASS_EN for same-cycle writeback forwarding
package rv32_isa;
    localparam int RegWidth = 32;
    localparam int RegAddrWidth = 5;
endpackage

module register_file_sb
    import rv32_isa::*;
#(
    parameter int NRegs = 32,
    parameter int NReadPorts = 2
) (
    input  logic                               iClk,
    input  logic                               iRst,
    input  logic                               iWriteEn,
    input  logic [RegAddrWidth-1:0]            iAddr_Rd,
    input  logic [RegWidth-1:0]                iRd,
    input  logic                               iIssueEn,
    input  logic [RegAddrWidth-1:0]            iAddr_Issue,
    input  logic [NReadPorts*RegAddrWidth-1:0] iAddr_Rs,
    output logic [NReadPorts*RegWidth-1:0]     oRs,
    output logic [NReadPorts-1:0]              oRsReady,
    output logic [RegAddrWidth:0]              oPendingCount
);
    localparam int Depth = 2 ** RegAddrWidth;
    localparam logic [RegAddrWidth:0] NRegsW = (RegAddrWidth + 1)'(NRegs);

    // Entries at or above NRegs are never written, so they read back as zero and ready.
    logic [RegWidth-1:0] regs [Depth];
    logic [Depth-1:0] pending, pending_next;
    logic [RegAddrWidth:0] count;
    logic wr_ok, iss_ok, set_new, clr;

    assign wr_ok = iWriteEn && iAddr_Rd != '0 && {1'b0, iAddr_Rd} < NRegsW;
    assign iss_ok = iIssueEn && iAddr_Issue != '0 && {1'b0, iAddr_Issue} < NRegsW;
    assign set_new = iss_ok && !pending[iAddr_Issue];
    assign clr = wr_ok && pending[iAddr_Rd] && !(iss_ok && iAddr_Issue == iAddr_Rd);
    assign oPendingCount = count;

    // Writeback clears the pending bit first so a same-address issue wins.
    always_comb begin
        pending_next = pending;
        if (wr_ok) pending_next[iAddr_Rd] = 1'b0;
        if (iss_ok) pending_next[iAddr_Issue] = 1'b1;
    end

    // Register data, pending bits and the running popcount; reset overrides everything.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < Depth; i++) regs[i] <= '0;
            pending <= '0;
            count <= '0;
        end else begin
            if (wr_ok) regs[iAddr_Rd] <= iRd;
            pending <= pending_next;
            count <= count + {{RegAddrWidth{1'b0}}, set_new} - {{RegAddrWidth{1'b0}}, clr};
        end
    end

    for (genvar p = 0; p < NReadPorts; p++) begin : g_rd
        logic [RegAddrWidth-1:0] a;
        assign a = iAddr_Rs[p*RegAddrWidth +: RegAddrWidth];
`ifdef REGFILE_BYPASS_EN
        logic byp;
        assign byp = wr_ok && a == iAddr_Rd;
        assign oRs[p*RegWidth +: RegWidth] = byp ? iRd : regs[a];
        assign oRsReady[p] = byp ? !(iss_ok && iAddr_Issue == a) : !pending[a];
`else
        assign oRs[p*RegWidth +: RegWidth] = regs[a];
        assign oRsReady[p] = !pending[a];
`endif
    end
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed and random checks of register_file_sb against an array-based reference model
module tb_register_file_sb;
    import rv32_isa::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, we, ie;
    logic [4:0] ard, aiss;
    logic [31:0] rd;
    logic [9:0] ars;
    logic [63:0] rs;
    logic [1:0] rdy;
    logic [5:0] cnt;

    int compared = 0;
    int mism = 0;
    logic [31:0] mem [32];
    bit pend [32];

    register_file_sb #(.NRegs(32), .NReadPorts(2)) dut (
        .iClk(clk), .iRst(rst), .iWriteEn(we), .iAddr_Rd(ard), .iRd(rd),
        .iIssueEn(ie), .iAddr_Issue(aiss), .iAddr_Rs(ars),
        .oRs(rs), .oRsReady(rdy), .oPendingCount(cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic i, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1);
        rst = r; we = w; ard = a; rd = d; ie = i; aiss = ia; ars = {r1, r0};
    endtask

    function automatic logic [32:0] exp_read(input logic [4:0] a);
        if (a == 0) return {1'b1, 32'h0};
`ifdef REGFILE_BYPASS_EN
        if (we && ard != 0 && a == ard) return {!(ie && aiss == a), rd};
`endif
        return {!pend[a], mem[a]};
    endfunction

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(pend[i]);
        return n;
    endfunction

    task automatic check_reads(input string tag);
        logic [32:0] e;
        #3;
        for (int p = 0; p < 2; p++) begin
            e = exp_read(ars[p*5 +: 5]);
            chk({tag, "_data"}, rs[p*32 +: 32], e[31:0]);
            chk({tag, "_rdy"}, {31'b0, rdy[p]}, {31'b0, e[32]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
        end else begin
            if (we && ard != 0) begin mem[ard] = rd; pend[ard] = 0; end
            if (ie && aiss != 0) pend[aiss] = 1;
        end
        #1;
        chk("count", {26'b0, cnt}, popcount());
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // reset clears a just-written register
        set_in(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 5, 5);
        check_reads("x5_wr");
        chk("x5_value", rs[31:0], 32'hDEADBEEF);
        set_in(1, 0, 0, 0, 0, 0, 5, 5);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 5, 0);
        check_reads("x5_rst");
        chk("x5_after_rst", rs[31:0], 32'h0);
        chk("x5_rdy_after_rst", {31'b0, rdy[0]}, 32'h1);
        chk("cnt_after_rst", {26'b0, cnt}, 32'h0);
        // x0 ignores writes and issues
        set_in(0, 1, 0, 32'h12345678, 1, 0, 0, 0);
        check_reads("x0_same");
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_reads("x0_after");
        chk("x0_value", rs[31:0], 32'h0);
        chk("x0_rdy", {31'b0, rdy[0]}, 32'h1);
        chk("x0_cnt", {26'b0, cnt}, 32'h0);
        // scoreboard issue then writeback
        set_in(0, 0, 0, 0, 1, 3, 3, 3);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 3, 3);
        check_reads("x3_pend");
        chk("x3_rdy_pend", {31'b0, rdy[0]}, 32'h0);
        chk("x3_cnt_pend", {26'b0, cnt}, 32'h1);
        set_in(0, 1, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
        check_reads("x3_wb");
        tick();
        set_in(0, 0, 0, 0, 0, 0, 3, 3);
        check_reads("x3_done");
        chk("x3_value", rs[31:0], 32'hA5A5A5A5);
        chk("x3_rdy_done", {31'b0, rdy[1]}, 32'h1);
        chk("x3_cnt_done", {26'b0, cnt}, 32'h0);
        // simultaneous issue and writeback on a pending register
        set_in(0, 0, 0, 0, 1, 7, 7, 7);
        tick();
        set_in(0, 1, 7, 32'h11, 1, 7, 7, 7);
        check_reads("x7_both");
        tick();
        set_in(0, 0, 0, 0, 0, 0, 7, 7);
        check_reads("x7_after");
        chk("x7_value", rs[31:0], 32'h11);
        chk("x7_rdy", {31'b0, rdy[0]}, 32'h0);
        chk("x7_cnt", {26'b0, cnt}, 32'h1);
        // same-cycle write and read on both ports
        set_in(0, 1, 9, 32'h1, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 9, 32'hCAFEF00D, 0, 0, 9, 9);
        check_reads("x9_byp");
`ifdef REGFILE_BYPASS_EN
        chk("x9_p0", rs[31:0], 32'hCAFEF00D);
        chk("x9_p1", rs[63:32], 32'hCAFEF00D);
`else
        chk("x9_p0", rs[31:0], 32'h1);
        chk("x9_p1", rs[63:32], 32'h1);
`endif
        tick();
        // pending count saturation at NRegs-1
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i < 32; i++) begin
            set_in(0, 0, 0, 0, 1, 5'(i), 5'(i), 0);
            tick();
        end
        chk("cnt_full", {26'b0, cnt}, 32'd31);
        set_in(0, 0, 0, 0, 1, 1, 1, 31);
        tick();
        chk("cnt_reissue", {26'b0, cnt}, 32'd31);
        // random traffic, biased toward a few registers to force collisions
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 500; n++) begin
            set_in($urandom_range(0, 60) == 0, 1'($urandom), 5'($urandom_range(0, n[0] ? 31 : 6)), $urandom,
                   1'($urandom), 5'($urandom_range(0, n[1] ? 31 : 6)),
                   5'($urandom_range(0, 6)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) ars[9:5] = ard;
            check_reads("rnd");
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
